// File: rtl/vram_pkg.sv
// vram_arbiter shared types: FSM states, bus owner tags
// and default geometry.
package vram_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_LINE_WORDS = 60;
  localparam int DEF_CPU_SLOT   = 4;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_SCAN,
    OWN_CPU
  } owner_t;

endpackage

// File: rtl/vram_slot_sched.sv
// Slot counter and per-cycle VRAM grant decision
// between scanout and the CPU.
module vram_slot_sched
  import vram_pkg::*;
#(
  parameter int CPU_SLOT = DEF_CPU_SLOT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_t state,
  input  logic   line_start,
  input  logic   cpu_pend,
  output logic   gnt_scan,
  output logic   gnt_cpu
);

  localparam int SW = $clog2(CPU_SLOT);
  localparam logic [SW-1:0] LAST = SW'(CPU_SLOT - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  always_comb begin
    gnt_scan = 1'b0;
    gnt_cpu  = 1'b0;
    slot_d   = '0;
    if (line_start) begin
      // the start cycle itself is slot 0 and issues word 0
      gnt_scan = 1'b1;
      slot_d   = ONE;
    end else if (state == ST_SCAN) begin
      gnt_cpu  = cpu_pend && (slot_q == LAST);
      gnt_scan = !gnt_cpu;
      slot_d   = (slot_q == LAST) ? '0 : slot_q + ONE;
    end else begin
      gnt_cpu = cpu_pend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: line-burst scanout with
// reserved CPU slots and a two-stage read return.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int CPU_SLOT   = DEF_CPU_SLOT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_addr,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_done,
  output logic              scan_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IW = $clog2(LINE_WORDS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  state_t state_q, state_d;
  owner_t own_q, own_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic last_q, last_d;
  logic en_d, we_d;
  logic valid_q, done_q, ack_q, rd_q, ovr_q;
  logic cpu_pend, gnt_scan, gnt_cpu;

  // granted from grant until its ack cycle ends
  assign cpu_pend = cpu_req && (own_q != OWN_CPU) && !ack_q;

  vram_slot_sched #(
    .CPU_SLOT (CPU_SLOT)
  ) u_sched (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state_q),
    .line_start (line_start),
    .cpu_pend   (cpu_pend),
    .gnt_scan   (gnt_scan),
    .gnt_cpu    (gnt_cpu)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    own_d   = OWN_NONE;
    last_d  = 1'b0;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    if (gnt_scan) begin
      en_d  = 1'b1;
      own_d = OWN_SCAN;
      if (line_start) begin
        base_d = line_addr;
        addr_d = line_addr;
        last_d = (LINE_WORDS == 1);
        idx_d  = ONE_IDX;
      end else begin
        addr_d = base_q + ADDR_W'(idx_q);
        last_d = (idx_q == LAST_IDX);
        idx_d  = idx_q + ONE_IDX;
      end
      state_d = last_d ? ST_IDLE : ST_SCAN;
    end else if (gnt_cpu) begin
      en_d    = 1'b1;
      we_d    = cpu_we;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      own_d   = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      own_q     <= OWN_NONE;
      idx_q     <= '0;
      base_q    <= '0;
      last_q    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      rd_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      last_q    <= last_d;
      mem_en    <= en_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      valid_q   <= (own_q == OWN_SCAN);
      done_q    <= (own_q == OWN_SCAN) && last_q;
      ack_q     <= (own_q == OWN_CPU);
      rd_q      <= (own_q == OWN_CPU) && !mem_we;
      ovr_q     <= line_start && (state_q == ST_SCAN);
    end
  end

  // read data returns one cycle after the access
  assign scan_valid   = valid_q;
  assign scan_data    = valid_q ? mem_rdata : '0;
  assign scan_done    = done_q;
  assign scan_overrun = ovr_q;
  assign cpu_ack      = ack_q;
  assign cpu_rdata    = rd_q ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a VRAM model and
// an address-order scoreboard for scanout and CPU traffic.
module tb_vram_arbiter;

  localparam int LW = 60;
  localparam int CS = 4;

  logic        clk;
  logic        rst_n;
  logic        line_start;
  logic [15:0] line_addr;
  logic        scan_valid;
  logic [15:0] scan_data;
  logic        scan_done;
  logic        scan_overrun;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [15:0] vram [0:65535];
  logic [15:0] mdl [0:65535];

  int          starts_issued = 0;
  int          starts_seen = 0;
  logic [15:0] start_base = '0;
  logic [15:0] cur_base = '0;
  int          cur_k = 0;
  bit          cur_active = 0;
  int          lat = 0;

  vram_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .LINE_WORDS (LW),
    .CPU_SLOT   (CS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_start   (line_start),
    .line_addr    (line_addr),
    .scan_valid   (scan_valid),
    .scan_data    (scan_data),
    .scan_done    (scan_done),
    .scan_overrun (scan_overrun),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      vram[i] = 16'(i) ^ 16'h5A5A;
      mdl[i]  = 16'(i) ^ 16'h5A5A;
    end
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else        mem_rdata <= vram[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (!rst_n || !cpu_req) lat = 0;
    else if (!cpu_ack)      lat = lat + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] ea;
    bit ok;
    if (!rst_n) begin
      cur_active  = 0;
      cur_k       = 0;
      starts_seen = starts_issued;
    end else begin
      if (scan_valid) begin
        ea = cur_base + 16'(cur_k);
        ok = 0;
        if (cur_active && scan_data == mdl[ea]) begin
          ok = 1;
        end else if (starts_seen != starts_issued &&
                     scan_data == mdl[start_base]) begin
          cur_base    = start_base;
          cur_k       = 0;
          cur_active  = 1;
          starts_seen = starts_issued;
          ok = 1;
        end
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL scan_word actual=%h expected=%h t=%0t",
                   scan_data, mdl[ea], $time);
        end
        cur_k++;
        chk("scan_done_model", 32'(scan_done), 32'(cur_k == LW));
        if (cur_k == LW) cur_active = 0;
      end else begin
        chk("done_without_valid", 32'(scan_done), 32'(0));
      end
      if (cpu_ack) begin
        chk("ack_has_req", 32'(cpu_req), 32'(1));
        chk("cpu_latency_bound", 32'(lat <= CS + 2), 32'(1));
        if (!cpu_we)
          chk("cpu_rdata_model", 32'(cpu_rdata), 32'(mdl[cpu_addr]));
        else
          mdl[cpu_addr] = cpu_wdata;
      end
      if (mem_we)
        chk("we_only_cpu_write", 32'(cpu_req && cpu_we), 32'(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input bit we, input logic [15:0] a,
                            input logic [15:0] wd,
                            output int n, output logic [15:0] rd);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    n = 0; rd = '0;
    while (n < 12) begin
      tick(); n++;
      if (cpu_ack) break;
    end
    if (!cpu_ack) chk("cpu_ack_timeout", 32'(0), 32'(1));
    rd = cpu_rdata;
    tick();
    cpu_req = 0;
    tick();
  endtask

  task automatic run_burst(input logic [15:0] base, input bit cpu,
                           input bit we, input logic [15:0] ca,
                           input logic [15:0] wd,
                           input logic [15:0] exp_rd);
    int n;
    logic [15:0] a;
    n = cpu ? LW + 1 : LW;
    line_start = 1; line_addr = base;
    start_base = base; starts_issued++;
    if (cpu) begin
      cpu_req = 1; cpu_we = we; cpu_addr = ca; cpu_wdata = wd;
    end
    tick();
    line_start = 0;
    for (int k = 0; k < n + 3; k++) begin
      a = base + 16'((cpu && k > 3) ? k - 1 : k);
      if (k < n) begin
        chk("mem_en", 32'(mem_en), 32'(1));
        if (cpu && k == 3) begin
          chk("cpu_slot_addr", 32'(mem_addr), 32'(ca));
          chk("cpu_slot_we", 32'(mem_we), 32'(we));
        end else begin
          chk("scan_addr", 32'(mem_addr), 32'(a));
          chk("scan_we", 32'(mem_we), 32'(0));
        end
      end else begin
        chk("idle_en", 32'(mem_en), 32'(0));
      end
      chk("scan_valid",
          32'(scan_valid), 32'(k >= 1 && k <= n && !(cpu && k == 4)));
      chk("scan_done", 32'(scan_done), 32'(k == n));
      chk("scan_overrun", 32'(scan_overrun), 32'(0));
      chk("cpu_ack", 32'(cpu_ack), 32'(cpu && k == 4));
      if (cpu && k == 4)
        chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
      tick();
      if (k == 4) cpu_req = 0;
    end
  endtask

  initial begin
    int n;
    logic [15:0] rd;
    rst_n = 0; line_start = 0; line_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    #3;
    chk("rst_scan_valid", 32'(scan_valid), 32'(0));
    chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    chk("rst_mem_en", 32'(mem_en), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    tick(); tick();

    run_burst(16'h0100, 0, 0, '0, '0, '0);
    tick();

    cpu_access(1, 16'h0042, 16'hBEEF, n, rd);
    chk("idle_write_latency", 32'(n), 32'(2));
    cpu_access(0, 16'h0042, 16'h0000, n, rd);
    chk("idle_read_latency", 32'(n), 32'(2));
    chk("idle_read_data", 32'(rd), 32'hBEEF);

    run_burst(16'h0300, 1, 0, 16'h0500, '0, 16'h5F5A);
    run_burst(16'hFFFE, 1, 1, 16'h0700, 16'h1234, 16'h0000);
    cpu_access(0, 16'h0700, 16'h0000, n, rd);
    chk("slot_write_readback", 32'(rd), 32'h1234);

    line_start = 1; line_addr = 16'h1000;
    start_base = 16'h1000; starts_issued++;
    tick();
    line_start = 0;
    for (int k = 0; k < 73; k++) begin
      if (k < 70) begin
        chk("ovr_mem_en", 32'(mem_en), 32'(1));
        chk("ovr_addr", 32'(mem_addr),
            32'(k < 10 ? 16'h1000 + 16'(k) : 16'h2000 + 16'(k - 10)));
      end else begin
        chk("ovr_idle_en", 32'(mem_en), 32'(0));
      end
      chk("ovr_valid", 32'(scan_valid), 32'(k >= 1 && k <= 70));
      chk("ovr_pulse", 32'(scan_overrun), 32'(k == 10));
      chk("ovr_done", 32'(scan_done), 32'(k == 70));
      if (k == 9) begin
        line_start = 1; line_addr = 16'h2000;
        start_base = 16'h2000; starts_issued++;
      end
      tick();
      line_start = 0;
    end

    line_start = 1; line_addr = 16'h3000;
    start_base = 16'h3000; starts_issued++;
    tick();
    line_start = 0;
    for (int k = 0; k < 20; k++) tick();
    chk("pre_reset_addr", 32'(mem_addr), 32'h3014);
    #2 rst_n = 0;
    #1;
    chk("arst_scan_valid", 32'(scan_valid), 32'(0));
    chk("arst_scan_data", 32'(scan_data), 32'(0));
    chk("arst_scan_done", 32'(scan_done), 32'(0));
    chk("arst_overrun", 32'(scan_overrun), 32'(0));
    chk("arst_cpu_ack", 32'(cpu_ack), 32'(0));
    chk("arst_cpu_rdata", 32'(cpu_rdata), 32'(0));
    chk("arst_mem_en", 32'(mem_en), 32'(0));
    chk("arst_mem_we", 32'(mem_we), 32'(0));
    chk("arst_mem_addr", 32'(mem_addr), 32'(0));
    chk("arst_mem_wdata", 32'(mem_wdata), 32'(0));
    tick(); tick();
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_valid", 32'(scan_valid), 32'(0));
      chk("post_rst_ack", 32'(cpu_ack), 32'(0));
      chk("post_rst_en", 32'(mem_en), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
